// File: rtl/uart_tx_scheduler.sv
// Transmit-side sequencer for the buffered UART: pops bytes from the TX fifo,
// hands them to the transmitter with a start/busy handshake, and supports a fifo flush.
module uart_tx_scheduler #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_pop,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic [COUNT_WIDTH-1:0] tx_count,
  output logic                   active,
  output logic                   flush_done
);

  // The gap counter loads GAP_CYCLES-1 and counts down to zero.
  localparam int unsigned GapWidth = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapWidth-1:0] GapLoad =
      GapWidth'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StCapture,
    StStart,
    StWaitHi,
    StWaitLo,
    StGap,
    StFlush
  } state_e;

  state_e                state_q;
  logic                  flush_pending_q;
  logic [GapWidth-1:0]   gap_cnt_q;

  assign active   = (state_q != StIdle);
  // While flushing, pop combinationally so the fifo drains one entry per cycle.
  assign fifo_pop = (state_q == StPop) || ((state_q == StFlush) && !fifo_empty);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      flush_pending_q <= 1'b0;
      gap_cnt_q       <= '0;
      tx_start        <= 1'b0;
      tx_data         <= '0;
      tx_count        <= '0;
      flush_done      <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      flush_done <= 1'b0;
      if (flush) begin
        flush_pending_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (flush_pending_q) begin
            // A flush arriving in the same cycle stays latched for a further pass.
            state_q         <= StFlush;
            flush_pending_q <= flush;
          end else if (enable && !fifo_empty && !tx_busy) begin
            state_q <= StPop;
          end
        end
        StPop: begin
          state_q <= StCapture;
        end
        StCapture: begin
          tx_data  <= fifo_data;
          tx_start <= 1'b1;
          state_q  <= StStart;
        end
        StStart: begin
          tx_count <= tx_count + 1'b1;
          state_q  <= StWaitHi;
        end
        StWaitHi: begin
          if (tx_busy) begin
            state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (!tx_busy) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt_q <= GapLoad;
              state_q   <= StGap;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        StFlush: begin
          if (fifo_empty) begin
            flush_done <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: fifo and transmitter models plus a
// scoreboard of expected bytes, byte count and timing.
module tb_uart_tx_scheduler;

  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 2;
  localparam int unsigned CW  = 4;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic          enable     = 1'b0;
  logic          flush      = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_pop;
  logic          tx_busy    = 1'b0;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] tx_count;
  logic          active;
  logic          flush_done;

  int n_assert  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int fd_cnt    = 0;
  int busy_len  = 10;
  int busy_left = 0;
  int exp_count = 0;
  bit chk_cnt   = 1'b0;

  int            start_cyc[$];
  int            pop_cyc[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clock = ~clock;

  uart_tx_scheduler #(
    .DATA_WIDTH (DW),
    .GAP_CYCLES (GAP),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_count  (tx_count),
    .active    (active),
    .flush_done(flush_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] b);
    pend_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_quiet(input string tag);
    int quiet = 0;
    int n     = 0;
    while (quiet < 3 && n < 2000) begin
      tick();
      n++;
      if (!active && !tx_busy && (fifo_empty || !enable)) quiet++;
      else quiet = 0;
    end
    check({"quiet_timeout_", tag}, 32'(quiet < 3), 0);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int n = 0;
    while (start_cyc.size() < target && n < 500) begin
      tick();
      n++;
    end
    check({"start_timeout_", tag}, 32'(start_cyc.size() < target), 0);
  endtask

  // Fifo model: a pop delivers the head on the next cycle; pushes land on the next edge.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fifo_pop && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
  always @(posedge clock) begin
    if (tx_start) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len - 1;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  // Scoreboard: every start carries the next pushed byte and bumps the count mod 2^CW.
  always @(negedge clock) begin
    if (chk_cnt) begin
      check("tx_count_after_start", 32'(tx_count), exp_count);
      chk_cnt = 1'b0;
    end
    if (tx_start) begin
      start_cyc.push_back(cyc);
      check("start_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      check("start_while_busy", 32'(tx_busy), 0);
      exp_count = (exp_count + 1) % (1 << CW);
      chk_cnt   = 1'b1;
    end
    if (fifo_pop) begin
      pop_cyc.push_back(cyc);
      check("pop_while_empty", 32'(fifo_empty), 0);
    end
    if (flush_done) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin
    int s0;
    int p0;
    int f0;
    int n;

    repeat (3) tick();
    reset = 1'b0;
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_count", 32'(tx_count), 0);
    check("rst_active", 32'(active), 0);
    check("rst_fifo_pop", 32'(fifo_pop), 0);
    check("rst_flush_done", 32'(flush_done), 0);

    // Idle with an empty fifo.
    repeat (20) tick();
    check("idle_pops", pop_cyc.size(), 0);
    check("idle_starts", start_cyc.size(), 0);
    check("idle_active", 32'(active), 0);
    check("idle_count", 32'(tx_count), 0);

    // Three bytes back to back, busy 10, gap 2 -> 17-cycle period.
    busy_len = 10;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    tick();
    s0     = start_cyc.size();
    enable = 1'b1;
    wait_quiet("burst");
    check("burst_starts", start_cyc.size() - s0, 3);
    if (start_cyc.size() >= s0 + 3) begin
      check("burst_period_1", start_cyc[s0+1] - start_cyc[s0], 17);
      check("burst_period_2", start_cyc[s0+2] - start_cyc[s0+1], 17);
    end
    check("burst_count", 32'(tx_count), 3);
    check("burst_fifo_empty", 32'(fifo_empty), 1);
    check("burst_active", 32'(active), 0);

    // Flush while the first of four bytes is in WAIT_LO.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    tick();
    s0     = start_cyc.size();
    f0     = fd_cnt;
    enable = 1'b1;
    n      = 0;
    while (!tx_busy && n < 50) begin
      tick();
      n++;
    end
    check("flush_busy_timeout", 32'(tx_busy), 1);
    p0 = pop_cyc.size();
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_quiet("flush");
    check("flush_starts", start_cyc.size() - s0, 1);
    check("flush_pops", pop_cyc.size() - p0, 3);
    if (pop_cyc.size() == p0 + 3) check("flush_pops_consec", pop_cyc[p0+2] - pop_cyc[p0], 2);
    check("flush_done_pulses", fd_cnt - f0, 1);
    check("flush_fifo_drained", fifo_q.size(), 0);
    check("flush_count", 32'(tx_count), 4);
    exp_q.delete();
    enable = 1'b0;

    // Drop enable during the second of three bytes.
    for (int i = 0; i < 3; i++) push(8'($urandom));
    tick();
    s0     = start_cyc.size();
    enable = 1'b1;
    wait_starts(s0 + 2, "en_drop");
    enable = 1'b0;
    wait_quiet("en_drop");
    check("en_drop_starts", start_cyc.size() - s0, 2);
    check("en_drop_left", fifo_q.size(), 1);
    repeat (10) tick();
    check("en_hold_starts", start_cyc.size() - s0, 2);
    check("en_hold_active", 32'(active), 0);
    enable = 1'b1;
    wait_quiet("en_resume");
    check("en_resume_starts", start_cyc.size() - s0, 3);
    check("en_resume_empty", 32'(fifo_empty), 1);
    check("en_resume_count", 32'(tx_count), 7);

    // Reset (with a simultaneous flush) during WAIT_HI; remaining bytes resent.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    tick();
    s0     = start_cyc.size();
    f0     = fd_cnt;
    enable = 1'b1;
    wait_starts(s0 + 1, "rst_mid");
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset     = 1'b0;
    flush     = 1'b0;
    exp_count = 0;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_tx_count", 32'(tx_count), 0);
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_fifo_pop", 32'(fifo_pop), 0);
    check("mid_rst_flush_done", 32'(flush_done), 0);
    wait_quiet("rst_resend");
    check("rst_resend_starts", start_cyc.size() - s0, 3);
    check("rst_resend_count", 32'(tx_count), 2);
    check("rst_flush_dropped", fd_cnt - f0, 0);
    check("rst_resend_empty", fifo_q.size(), 0);

    // Counter wrap: 17 bytes from reset with a 4-bit counter.
    enable = 1'b0;
    reset  = 1'b1;
    tick();
    reset     = 1'b0;
    exp_count = 0;
    busy_len  = int'($urandom_range(1, 4));
    for (int i = 0; i < 17; i++) push(8'($urandom));
    tick();
    s0     = start_cyc.size();
    enable = 1'b1;
    wait_quiet("wrap");
    check("wrap_starts", start_cyc.size() - s0, 17);
    check("wrap_count", 32'(tx_count), 1);
    check("wrap_empty", fifo_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Sequences the transmit side of the buffered UART. Drains bytes from the TX fifo one at a time and hands each byte to the UART transmitter with a start/busy handshake. Enforces a programmable inter-byte gap. Supports a flush that discards the fifo contents without transmitting them. Sits between the TX fifo read port and the UART transmitter.

Parameters:
DATA_WIDTH, 8, width of fifo data and transmitter byte
GAP_CYCLES, 0, idle clock cycles inserted after each byte's tx_busy falls (0 = no gap)
COUNT_WIDTH, 16, width of transmitted-byte counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  permits starting new bytes; sampled only in IDLE
flush  input  1  single-cycle pulse: discard fifo contents
fifo_empty  input  1  fifo empty flag, updated on the same edge as a pop
fifo_data  input  DATA_WIDTH  fifo read data, valid the cycle after fifo_pop
fifo_pop  output  1  fifo read strobe, one entry per asserted cycle
tx_busy  input  1  transmitter busy; rises the cycle after tx_start, falls at end of stop bit
tx_start  output  1  one-cycle pulse: transmitter latches tx_data
tx_data  output  DATA_WIDTH  registered byte to transmit
tx_count  output  COUNT_WIDTH  bytes handed to transmitter since reset, wraps
active  output  1  high in any state other than IDLE
flush_done  output  1  one-cycle pulse when a flush completes

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Reset in any state takes effect at the next edge: state=IDLE, fifo_pop=0, tx_start=0, tx_data=0, tx_count=0, active=0, flush_done=0, flush_pending=0, gap counter=0.
- All outputs are registered, except fifo_pop in FLUSH and active, which are decoded from state.
- flush_pending is set by flush in any state. It is cleared on entry to FLUSH.
- States:
  - IDLE: flush_pending -> FLUSH; this has priority over transmit. Else, if enable && !fifo_empty && !tx_busy -> POP. Else stay.
  - POP: fifo_pop=1 for exactly this cycle -> CAPTURE.
  - CAPTURE: tx_data <= fifo_data -> START.
  - START: tx_start=1 for one cycle; tx_count <= tx_count+1 (mod 2^COUNT_WIDTH) -> WAIT_HI.
  - WAIT_HI: stay until tx_busy=1 -> WAIT_LO.
  - WAIT_LO: stay until tx_busy=0 -> GAP if GAP_CYCLES>0, else IDLE.
  - GAP: count GAP_CYCLES cycles -> IDLE.
  - FLUSH: fifo_pop = !fifo_empty each cycle. When fifo_empty=1 -> IDLE, with flush_done=1 in that transition cycle. Nothing is transmitted; tx_count is unchanged.
- Latency: from IDLE with data present, tx_start is asserted 3 cycles later (IDLE->POP->CAPTURE->START). Back-to-back byte period = busy duration + GAP_CYCLES + 5.
- enable deassert mid-byte: the current byte completes through GAP; no further pops.
- flush mid-byte: latched; the current byte completes; FLUSH follows IDLE.
- flush while fifo is already empty: FLUSH is entered for one cycle with no pop, then flush_done.
- Simultaneous reset and flush: reset wins; flush is dropped.
- fifo_pop never asserts while fifo_empty=1. tx_start never asserts while tx_busy=1.
- tx_count wraps from 2^COUNT_WIDTH-1 to 0 without any flag.

Test Plan:
- Reset, then idle with an empty fifo for 20 cycles -> fifo_pop=0, tx_start=0, active=0, tx_count=0.
- Preload fifo 0x11,0x22,0x33; enable=1; transmitter model busy 10 cycles; GAP_CYCLES=2 -> tx_start pulses carry 0x11, 0x22, 0x33 in order, 17 cycles apart; tx_count=3; fifo empty; active=0 at end.
- Preload 4 bytes; pulse flush while the first byte is in WAIT_LO -> the first byte completes; then exactly 3 consecutive fifo_pop cycles; flush_done one cycle; tx_count=1.
- Drop enable during the second of 3 bytes -> the second byte completes; the third stays in the fifo; the state holds in IDLE; re-assert enable -> the third byte is sent.
- Assert reset for one cycle during WAIT_HI -> all outputs return to reset values at the next edge; the remaining fifo bytes are resent after reset releases with enable=1.
- COUNT_WIDTH=4: send 17 bytes -> tx_count reads 1 after the 17th tx_start.
